rr_req_arbiter: RTL and testbench

//  - Round-robin arbiter sharing one resource between N requesters via a req/gnt handshake.
//  - Registered grant: a request sampled at posedge clk is granted no earlier than the next edge.
//  - A grant is held while the owner keeps req high, bounded by HOLD_MAX cycles.
//  - Sits in front of any shared datapath. Its contract is written so it can be checked

---
 rtl/arb_pkg.sv | 30 +++
 rtl/rr_req_arbiter_pick.sv | 31 +++
 rtl/rr_req_arbiter.sv | 100 ++++++++++
 tb/tb_rr_req_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and the reference round-robin pick function for the request arbiter.
package arb_pkg;

   typedef enum logic [1:0] {IDLE, GRANT, GAP} arb_state_t;

   localparam int MAX_N = 16;

   // Winner is the first set bit scanning last_id+1, last_id+2, ... modulo n.
   function automatic logic [3:0] rr_next(input logic [MAX_N-1:0] req,
                                          input logic [3:0]       last_id,
                                          input int               n);
      logic [3:0] win;
      logic       found;
      int         idx;
      win   = '0;
      found = 1'b0;
      for (int k = 1; k <= MAX_N; k++) begin
         if (k <= n) begin
            idx = {28'd0, last_id} + k;
            if (idx >= n) idx = idx - n;
            if (!found && req[idx[3:0]]) begin
               win   = idx[3:0];
               found = 1'b1;
            end
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/rr_req_arbiter_pick.sv
// Rotating priority encoder: lowest priority goes to last_id, highest to last_id+1.
module rr_pick
   import arb_pkg::*;
#(
   parameter int N = 4,
   localparam int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] last_id,
   output logic [IDW-1:0] winner,
   output logic           any
);

   always_comb begin
      logic found;
      int   idx;
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = 1; k <= N; k++) begin
         idx = {{(32-IDW){1'b0}}, last_id} + k;
         if (idx >= N) idx = idx - N;
         if (!found && req[idx[IDW-1:0]]) begin
            winner = idx[IDW-1:0];
            found  = 1'b1;
         end
      end
      any = |req;
   end

endmodule

// File: rtl/rr_req_arbiter.sv
// Round-robin req/gnt arbiter with registered one-hot grant and bounded hold time.
//  state | meaning
//  IDLE  | no owner; arbitrate any pending request on the next edge
//  GRANT | one owner holds gnt; release, hand over back-to-back, or time out
//  GAP   | one dead cycle after a forced release, timeout pulse high
module rr_req_arbiter
   import arb_pkg::*;
#(
   parameter int N        = 4,
   parameter int HOLD_MAX = 8,
   localparam int IDW     = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id,
   output logic           gnt_vld,
   output logic           timeout
);

   localparam int HCW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
   localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_MAX - 1);

   arb_state_t     r_state;
   logic [N-1:0]   r_gnt;
   logic [IDW-1:0] r_gnt_id;
   logic [IDW-1:0] r_last_id;
   logic [HCW-1:0] r_hold_cnt;
   logic           r_gnt_vld;
   logic           r_timeout;
   logic [IDW-1:0] w_winner;
   logic           w_any;
   logic [N-1:0]   w_win_oh;

   rr_pick #(.N(N)) u_pick (
      .req     (req),
      .last_id (r_last_id),
      .winner  (w_winner),
      .any     (w_any)
   );

   assign w_win_oh = N'(1) << w_winner;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_gnt      <= '0;
         r_gnt_id   <= '0;
         r_gnt_vld  <= 1'b0;
         r_timeout  <= 1'b0;
         r_hold_cnt <= '0;
         r_last_id  <= IDW'(N - 1);
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_gnt      <= w_win_oh;
                  r_gnt_id   <= w_winner;
                  r_gnt_vld  <= 1'b1;
                  r_last_id  <= w_winner;
                  r_hold_cnt <= '0;
                  r_state    <= GRANT;
               end
            end
            GRANT: begin
               // Owner's req is already low here, so the picker cannot re-select it.
               if (!req[r_gnt_id]) begin
                  if (w_any) begin
                     r_gnt      <= w_win_oh;
                     r_gnt_id   <= w_winner;
                     r_last_id  <= w_winner;
                     r_hold_cnt <= '0;
                  end else begin
                     r_gnt     <= '0;
                     r_gnt_vld <= 1'b0;
                     r_state   <= IDLE;
                  end
               end else if (r_hold_cnt == HOLD_LAST) begin
                  r_gnt     <= '0;
                  r_gnt_vld <= 1'b0;
                  r_timeout <= 1'b1;
                  r_state   <= GAP;
               end else begin
                  r_hold_cnt <= r_hold_cnt + HCW'(1);
               end
            end
            GAP:     r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign gnt     = r_gnt;
   assign gnt_id  = r_gnt_id;
   assign gnt_vld = r_gnt_vld;
   assign timeout = r_timeout;

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Directed scenarios plus a randomized run against a cycle-level model of the arbitration rules.
module tb_rr_req_arbiter;

   localparam int N  = 4;
   localparam int HM = 8;
   // Worst wait: each of N-1 owners ahead holds HM cycles, then a GAP cycle and an IDLE cycle.
   localparam int STARVE_BOUND = (N - 1) * (HM + 2);

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] req = '0;
   logic [N-1:0] gnt;
   logic [1:0]   gnt_id;
   logic         gnt_vld;
   logic         timeout;

   int n_cmp = 0;
   int n_bad = 0;

   int m_owner;
   int m_held;
   int m_last;
   bit m_gap;

   rr_req_arbiter #(.N(N), .HOLD_MAX(HM)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .gnt_vld (gnt_vld),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt))
      else begin
         n_bad++;
         $display("FAIL sva_onehot0: gnt=%b", gnt);
      end

   for (genvar gi = 0; gi < N; gi++) begin : g_sva
      a_gnt_req: assert property (@(posedge clk) disable iff (rst) gnt[gi] |-> $past(req[gi]))
         else begin
            n_bad++;
            $display("FAIL sva_gnt_without_req[%0d]: gnt=1 but prior req=0", gi);
         end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   function automatic int rr_win(input logic [N-1:0] r, input int last);
      int idx;
      for (int k = 1; k <= N; k++) begin
         idx = (last + k) % N;
         if (r[idx[1:0]]) return idx;
      end
      return -1;
   endfunction

   task automatic model_step(input logic [N-1:0] r);
      int w;
      if (m_gap) begin
         m_gap = 1'b0;
      end else if (m_owner < 0 || !r[m_owner[1:0]]) begin
         w       = rr_win(r, m_last);
         m_owner = w;
         if (w >= 0) begin
            m_last = w;
            m_held = 1;
         end
      end else if (m_held == HM) begin
         m_owner = -1;
         m_gap   = 1'b1;
      end else begin
         m_held++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = '0;
      tick();
      tick();
      n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
      n_cmp++; if (gnt_id !== 2'd0) begin n_bad++; $display("FAIL rst_gnt_id: got %0d want 0", gnt_id); end
      n_cmp++; if (gnt_vld !== 1'b0) begin n_bad++; $display("FAIL rst_gnt_vld: got %b want 0", gnt_vld); end
      n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL rst_timeout: got %b want 0", timeout); end
   endtask

   task automatic test_first_grant();
      rst = 1'b0;
      req = 4'b0001;
      tick();
      n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL first_gnt: got %b want 0001", gnt); end
      n_cmp++; if (gnt_id !== 2'd0) begin n_bad++; $display("FAIL first_gnt_id: got %0d want 0", gnt_id); end
      n_cmp++; if (gnt_vld !== 1'b1) begin n_bad++; $display("FAIL first_gnt_vld: got %b want 1", gnt_vld); end
      req = 4'b0000;
      tick();
      n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL first_release: got %b want 0000", gnt); end
   endtask

   task automatic test_round_robin();
      int         order [5] = '{0, 1, 2, 3, 0};
      logic [3:0] e;
      req = 4'b1111;
      for (int s = 0; s < 5; s++) begin
         e = 4'(1 << order[s]);
         for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++;
            if (gnt !== e) begin
               n_bad++;
               $display("FAIL rr_order step %0d cyc %0d: got %b want %b", s, c, gnt, e);
            end
            if (c == 0) req = 4'b1111;
            else        req = (s == 4) ? 4'b0000 : (4'b1111 & ~e);
         end
      end
      tick();
      n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL rr_final_idle: got %b want 0000", gnt); end
   endtask

   task automatic test_timeout();
      logic [3:0] eg;
      logic       et;
      req = 4'b0100;
      for (int t = 1; t <= 11; t++) begin
         tick();
         eg = (t <= 8 || t == 11) ? 4'b0100 : 4'b0000;
         et = (t == 9);
         n_cmp++;
         if (gnt !== eg || timeout !== et) begin
            n_bad++;
            $display("FAIL hold_timeout cyc %0d: got gnt=%b to=%b want gnt=%b to=%b", t, gnt, timeout, eg, et);
         end
      end
      req = 4'b0000;
      tick();
      n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL timeout_release: got %b want 0000", gnt); end
   endtask

   task automatic test_simultaneous();
      req = 4'b0010;
      tick();
      n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL sim_setup: got %b want 0010", gnt); end
      req = 4'b0000;
      tick();
      req = 4'b1010;
      tick();
      n_cmp++;
      if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
         n_bad++;
         $display("FAIL sim_first: got gnt=%b id=%0d want gnt=1000 id=3", gnt, gnt_id);
      end
      req = 4'b0010;
      tick();
      n_cmp++;
      if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
         n_bad++;
         $display("FAIL sim_second: got gnt=%b id=%0d want gnt=0010 id=1", gnt, gnt_id);
      end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_reset_mid_grant();
      req = 4'b0010;
      tick();
      n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL midrst_setup: got %b want 0010", gnt); end
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (gnt !== 4'b0000 || gnt_vld !== 1'b0) begin
         n_bad++;
         $display("FAIL midrst_async_clear: got gnt=%b vld=%b want 0000/0", gnt, gnt_vld);
      end
      tick();
      rst = 1'b0;
      tick();
      n_cmp++;
      if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
         n_bad++;
         $display("FAIL midrst_regrant: got gnt=%b id=%0d want 0010 id=1", gnt, gnt_id);
      end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_random();
      logic [N-1:0] nr;
      logic [N-1:0] eg;
      int           wt [N];
      int           shown;
      do_reset();
      m_owner = -1;
      m_held  = 0;
      m_last  = N - 1;
      m_gap   = 1'b0;
      shown   = 0;
      for (int i = 0; i < N; i++) wt[i] = 0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (req[i]) nr[i] = !(gnt[i] && $urandom_range(3) == 0);
            else        nr[i] = ($urandom_range(2) == 0);
         end
         req = nr;
         @(posedge clk);
         model_step(nr);
         #1;
         eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
         n_cmp++;
         if (gnt !== eg || gnt_vld !== (m_owner >= 0) || timeout !== m_gap ||
             (m_owner >= 0 && gnt_id !== m_owner[1:0])) begin
            n_bad++;
            if (shown < 20) begin
               shown++;
               $display("FAIL rand cyc %0d req=%b: got gnt=%b id=%0d vld=%b to=%b want gnt=%b vld=%b to=%b",
                        cyc, nr, gnt, gnt_id, gnt_vld, timeout, eg, (m_owner >= 0), m_gap);
            end
         end
         for (int i = 0; i < N; i++) begin
            if (req[i] && !gnt[i]) wt[i]++;
            else                   wt[i] = 0;
            n_cmp++;
            if (wt[i] > STARVE_BOUND) begin
               n_bad++;
               if (shown < 20) begin
                  shown++;
                  $display("FAIL starvation req %0d cyc %0d: waited %0d max %0d", i, cyc, wt[i], STARVE_BOUND);
               end
            end
         end
      end
      req = '0;
      tick();
      tick();
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_first_grant();
      do_reset();
      test_round_robin();
      test_timeout();
      test_simultaneous();
      test_reset_mid_grant();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
